// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for a zero-latency asynchronous ROM.
// Owns the program counter and drives rom_addr with it every cycle.
// Buffers {pc, instr} pairs in a small FIFO and hands them to decode over a
// valid/ready handshake.
// Redirects flush the buffer and restart fetch at the new target.
// Optional build macro FETCH_PERF_EN adds three saturating 32-bit counters:
// perf_fetched, perf_stall and perf_flushed.

module fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    input  logic             out_ready,
    output logic             misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stall,
    output logic [31:0]      perf_flushed
`endif
);

    localparam int             AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] pc;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      count;
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic full;
    logic pop;
    logic push;

    assign full      = (count == FULL_COUNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A pop frees the head slot in the same cycle, so a full buffer can still accept a push.
    assign push      = !redirect_valid && (!full || pop);

    assign rom_addr  = pc;

    // Head entry is presented straight from buffer storage; zeros when empty.
    assign out_pc    = out_valid ? pc_mem[head]    : '0;
    assign out_instr = out_valid ? instr_mem[head] : '0;

    // Program counter: redirect target (word aligned) wins, else advance on push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[WIDTH-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + WIDTH'(4);
        end
    end

    // Buffer pointers and occupancy; a redirect discards everything buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + AW'(1);
            end
            if (push) begin
                tail <= tail + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Fetch storage: capture {pc, rom_data} at the tail on every push.
    // NOTE: storage has no reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= pc;
            instr_mem[tail] <= rom_data;
        end
    end

    // Sticky flag for a redirect target that was not word aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    logic [32:0] flushed_sum;

    assign flushed_sum = {1'b0, perf_flushed} + 33'(count);

    // Saturating performance counters: pushes, full-and-stalled cycles, flushed entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flushed <= '0;
        end else begin
            if (push && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (full && !pop && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven vectors plus a queue-based scoreboard model of
// the fetch buffer, with a hand-written asynchronous mid-stream reset.
// The ROM returns 0x1000 + word index for every address.

module tb_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        misalign_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_flushed;
`endif

    fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .misalign_err   (misalign_err)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_flushed   (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    assign rom_data = 32'h1000 + (rom_addr >> 2);

    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] erom;
        logic        emerr;
    } vec_t;

    localparam int NVEC         = 25;
    localparam int ASYNC_RST_AT = 17;

    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;

    // Scoreboard model: queue of expected {pc, instr} entries.
    logic [63:0] sb_q[$];
    logic [31:0] m_pc;
    logic        m_merr;
    int unsigned m_fetched, m_stall, m_flushed;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_pc      = 32'h0;
        m_merr    = 1'b0;
        m_fetched = 0;
        m_stall   = 0;
        m_flushed = 0;
    endtask

    // Compare DUT outputs against the scoreboard model.
    task automatic check_model(input string tag);
        logic        mv;
        logic [63:0] head;
        mv   = (sb_q.size() != 0);
        head = mv ? sb_q[0] : 64'h0;
        check({tag, " sb out_valid"}, {31'h0, out_valid}, {31'h0, mv});
        check({tag, " sb out_pc"}, out_pc, head[63:32]);
        check({tag, " sb out_instr"}, out_instr, head[31:0]);
        check({tag, " sb rom_addr"}, rom_addr, m_pc);
        check({tag, " sb misalign_err"}, {31'h0, misalign_err}, {31'h0, m_merr});
`ifdef FETCH_PERF_EN
        check({tag, " perf_fetched"}, perf_fetched, m_fetched);
        check({tag, " perf_stall"}, perf_stall, m_stall);
        check({tag, " perf_flushed"}, perf_flushed, m_flushed);
`endif
    endtask

    // Drive one cycle of stimulus, update the model, and check after the edge.
    task automatic step(input int idx);
        vec_t v;
        logic pop;
        logic push;
        string tag;
        v   = vecs[idx];
        tag = $sformatf("v%0d", idx);
        out_ready      = v.ready;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;

        pop  = v.ready && (sb_q.size() != 0);
        push = !v.rv && ((sb_q.size() < DEPTH) || pop);
        if ((sb_q.size() == DEPTH) && !pop) m_stall++;
        if (v.rv) begin
            m_flushed += sb_q.size();
            sb_q.delete();
            m_pc = {v.rpc[31:2], 2'b00};
            if (v.rpc[1:0] != 2'b00) m_merr = 1'b1;
        end else begin
            if (pop) void'(sb_q.pop_front());
            if (push) begin
                sb_q.push_back({m_pc, 32'h1000 + (m_pc >> 2)});
                m_pc = m_pc + 32'd4;
                m_fetched++;
            end
        end

        @(posedge clk);
        @(negedge clk);

        check({tag, " out_valid"}, {31'h0, out_valid}, {31'h0, v.ev});
        check({tag, " out_pc"}, out_pc, v.epc);
        check({tag, " out_instr"}, out_instr, v.einstr);
        check({tag, " rom_addr"}, rom_addr, v.erom);
        check({tag, " misalign_err"}, {31'h0, misalign_err}, {31'h0, v.emerr});
        check_model(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " out_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, " out_pc"}, out_pc, 32'h0);
        check({tag, " out_instr"}, out_instr, 32'h0);
        check({tag, " rom_addr"}, rom_addr, 32'h0);
        check({tag, " misalign_err"}, {31'h0, misalign_err}, 32'h0);
    endtask

    // Assert reset between edges and confirm the buffer empties without a clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        rst            = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        check_reset_state("post_rst");
    endtask

    initial begin
        //              ready rv  rpc            ev   epc            einstr         erom           emerr
        vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h1000,     32'h4,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h1001,     32'h8,        1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'h1002,     32'hC,        1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'h1002,     32'h10,       1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'h1002,     32'h10,       1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'h1002,     32'h10,       1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        32'h1003,     32'h14,       1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       32'h1004,     32'h18,       1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        32'h0,        32'h40,       1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       32'h1010,     32'h44,       1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       32'h1010,     32'h48,       1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'h43,       1'b0, 32'h0,        32'h0,        32'h40,       1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h80,       1'b0, 32'h0,        32'h0,        32'h80,       1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h80,       32'h1020,     32'h84,       1'b1};
        vecs[14] = '{1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFC, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 32'h40000FFF, 32'h0,        1'b1};
        vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h1000,     32'h4,        1'b1};
        vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h1000,     32'h4,        1'b0};
        vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h1000,     32'h8,        1'b0};
        vecs[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h1000,     32'h8,        1'b0};
        vecs[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h1000,     32'h8,        1'b0};
        vecs[21] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h1000,     32'h8,        1'b0};
        vecs[22] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h1001,     32'hC,        1'b0};
        vecs[23] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'h1002,     32'h10,       1'b0};
        vecs[24] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        32'h1003,     32'h14,       1'b0};

        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        for (int i = 0; i < NVEC; i++) begin
            if (i == ASYNC_RST_AT) async_reset();
            step(i);
`ifdef FETCH_PERF_EN
            if (i == 21) check("perf_stall after 5 idle cycles", perf_stall, 32'd3);
            if (i == 8)  check("perf_flushed after redirect", perf_flushed, 32'd2);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
